// File: rtl/fpu_d_seq_pkg.sv
// Shared types and constants for the double-precision FPU issue sequencer.
// The op-to-unit decode lives here so that every user maps op codes the same way.
package fpu_d_seq_pkg;

   localparam int FPU_UNITS = 6;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_D2L = 3'd4;
   localparam logic [2:0] OP_L2D = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Watchdog counter width depends on the module parameter, so it sits beside this struct
   typedef struct packed {
      state_e      state;
      logic [2:0]  sel;
      logic [63:0] a;
      logic [63:0] b;
      logic        sgn;
      logic        w32;
      logic        sub;
      logic [63:0] res;
      logic        exc;
      logic        timeout;
   } seq_reg_t;

   localparam seq_reg_t SEQ_REG_RST = '{
      state:   ST_IDLE,
      sel:     3'd0,
      a:       64'd0,
      b:       64'd0,
      sgn:     1'b0,
      w32:     1'b0,
      sub:     1'b0,
      res:     64'd0,
      exc:     1'b0,
      timeout: 1'b0
   };

   function automatic logic op_is_legal(input logic [2:0] op);
      return (op <= OP_L2D);
   endfunction

   // SUB shares the adder, so it maps onto unit 0
   function automatic logic [2:0] op_to_unit(input logic [2:0] op);
      logic [2:0] unit;
      case (op)
         OP_SUB:                                  unit = OP_ADD;
         OP_ADD, OP_MUL, OP_DIV, OP_D2L, OP_L2D:  unit = op;
         default:                                 unit = 3'd0;
      endcase
      return unit;
   endfunction

   function automatic logic [FPU_UNITS-1:0] unit_onehot(input logic [2:0] unit);
      logic [FPU_UNITS-1:0] v;
      v = '0;
      if (unit < 3'(FPU_UNITS)) begin
         v[unit] = 1'b1;
      end else begin
         v = '0;
      end
      return v;
   endfunction

endpackage

// File: rtl/fpu_d_seq_if.sv
// Request, unit-issue and response channels of the FPU issue sequencer.
// slave is the sequencer side; master is the executor/unit side.
interface fpu_d_seq_if;
   import fpu_d_seq_pkg::*;

   logic                       i_flush;
   logic                       i_req_valid;
   logic                       o_req_ready;
   logic [2:0]                 i_req_op;
   logic                       i_req_signed;
   logic                       i_req_w32;
   logic [63:0]                i_req_a;
   logic [63:0]                i_req_b;
   logic [FPU_UNITS-1:0]       o_unit_ena;
   logic [63:0]                o_a;
   logic [63:0]                o_b;
   logic                       o_signed;
   logic                       o_w32;
   logic                       o_sub;
   logic [FPU_UNITS-1:0]       i_unit_valid;
   logic [64*FPU_UNITS-1:0]    i_unit_res;
   logic [FPU_UNITS-1:0]       i_unit_except;
   logic                       o_resp_valid;
   logic                       i_resp_ready;
   logic [63:0]                o_resp_res;
   logic                       o_resp_except;
   logic                       o_resp_timeout;

   modport slave (
      input  i_flush, i_req_valid, i_req_op, i_req_signed, i_req_w32, i_req_a, i_req_b,
      input  i_unit_valid, i_unit_res, i_unit_except, i_resp_ready,
      output o_req_ready, o_unit_ena, o_a, o_b, o_signed, o_w32, o_sub,
      output o_resp_valid, o_resp_res, o_resp_except, o_resp_timeout
   );

   modport master (
      output i_flush, i_req_valid, i_req_op, i_req_signed, i_req_w32, i_req_a, i_req_b,
      output i_unit_valid, i_unit_res, i_unit_except, i_resp_ready,
      input  o_req_ready, o_unit_ena, o_a, o_b, o_signed, o_w32, o_sub,
      input  o_resp_valid, o_resp_res, o_resp_except, o_resp_timeout
   );

endinterface

// File: rtl/fpu_d_seq.sv
// FPU issue sequencer: one operation in flight, single-cycle unit enable,
// registered response with watchdog timeout and synchronous flush.
module fpu_d_seq
   import fpu_d_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        i_clk,
   input  logic        i_nrst,
   fpu_d_seq_if.slave  bus
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_reg_t              reg_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [FPU_UNITS-1:0]  ena_r;
   logic [CNT_W-1:0]      cnt_inc_s;
   logic                  sel_valid_s;
   logic                  sel_except_s;
   logic [63:0]           sel_res_s;

   // Pick the selected unit's valid/result/exception; other units are invisible
   always_comb begin
      sel_valid_s  = 1'b0;
      sel_except_s = 1'b0;
      sel_res_s    = 64'd0;
      if (reg_r.sel < 3'(FPU_UNITS)) begin
         sel_valid_s  = bus.i_unit_valid[reg_r.sel];
         sel_except_s = bus.i_unit_except[reg_r.sel];
         sel_res_s    = bus.i_unit_res[{reg_r.sel, 6'd0} +: 64];
      end else begin
         sel_valid_s  = 1'b0;
         sel_except_s = 1'b0;
         sel_res_s    = 64'd0;
      end
   end

   // Saturating watchdog increment
   always_comb begin
      if (cnt_r == CNT_LAST) begin
         cnt_inc_s = cnt_r;
      end else begin
         cnt_inc_s = cnt_r + CNT_W'(1);
      end
   end

   // Sequencer FSM with latched operands and registered response
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         reg_r <= SEQ_REG_RST;
         cnt_r <= '0;
         ena_r <= '0;
      end else if (bus.i_flush) begin
         reg_r.state <= ST_IDLE;
         cnt_r       <= '0;
         ena_r       <= '0;
      end else begin
         ena_r <= '0;
         case (reg_r.state)
            ST_IDLE: begin
               if (bus.i_req_valid) begin
                  reg_r.sel <= op_to_unit(bus.i_req_op);
                  reg_r.a   <= bus.i_req_a;
                  reg_r.b   <= bus.i_req_b;
                  reg_r.sgn <= bus.i_req_signed;
                  reg_r.w32 <= bus.i_req_w32;
                  reg_r.sub <= (bus.i_req_op == OP_SUB);
                  cnt_r     <= '0;
                  if (op_is_legal(bus.i_req_op)) begin
                     reg_r.state <= ST_ISSUE;
                     ena_r       <= unit_onehot(op_to_unit(bus.i_req_op));
                  end else begin
                     reg_r.state   <= ST_RESP;
                     reg_r.res     <= 64'd0;
                     reg_r.exc     <= 1'b1;
                     reg_r.timeout <= 1'b0;
                  end
               end
            end
            // Counting starts here so a silent unit times out TIMEOUT_CYCLES after issue
            ST_ISSUE: begin
               cnt_r       <= cnt_inc_s;
               reg_r.state <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt_r <= cnt_inc_s;
               if (sel_valid_s) begin
                  reg_r.res     <= sel_res_s;
                  reg_r.exc     <= sel_except_s;
                  reg_r.timeout <= 1'b0;
                  reg_r.state   <= ST_RESP;
               end else if (cnt_r == CNT_LAST) begin
                  reg_r.res     <= 64'd0;
                  reg_r.exc     <= 1'b1;
                  reg_r.timeout <= 1'b1;
                  reg_r.state   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.i_resp_ready) begin
                  reg_r.state <= ST_IDLE;
               end
            end
            default: begin
               reg_r.state <= ST_IDLE;
            end
         endcase
      end
   end

   // Flush suppresses the enable, the response and acceptance in its own cycle
   assign bus.o_req_ready    = (reg_r.state == ST_IDLE) && !bus.i_flush;
   assign bus.o_unit_ena     = ena_r & {FPU_UNITS{~bus.i_flush}};
   assign bus.o_resp_valid   = (reg_r.state == ST_RESP) && !bus.i_flush;
   assign bus.o_resp_res     = reg_r.res;
   assign bus.o_resp_except  = reg_r.exc;
   assign bus.o_resp_timeout = reg_r.timeout;
   assign bus.o_a            = reg_r.a;
   assign bus.o_b            = reg_r.b;
   assign bus.o_signed       = reg_r.sgn;
   assign bus.o_w32          = reg_r.w32;
   assign bus.o_sub          = reg_r.sub;

endmodule
